// File: rtl/hall_input_filter.sv
// hall_input_filter: synchronizes and debounces the three hall sensor inputs,
// tracks commutation order (direction / sequence errors / invalid codes) and
// measures the commutation period.
// Optional feature macro: HALL_PERIOD_EN enables the commutation period counter;
// without it period and period_valid are tied to zero.

package hall_input_filter_pkg;
  typedef logic [2:0] hall_states_t;
endpackage

module hall_input_filter
  import hall_input_filter_pkg::*;
#(
  parameter int FILTER_CYCLES = 16,
  parameter int PERIOD_WIDTH  = 24
) (
  input  logic                    sys_clk,
  input  logic                    reset_n,
  input  logic [2:0]              hall_raw,
  output hall_states_t            hall_values,
  output logic                    hall_edge,
  output logic                    dir,
  output logic                    seq_error,
  output logic                    hall_fault,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic                    period_valid
);

  localparam int CNT_W = (FILTER_CYCLES > 2) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  logic [2:0]       sync1_r;
  logic [2:0]       sync2_r;
  logic [2:0]       cand_r;
  logic [CNT_W-1:0] stab_cnt_r;
  state_t           state_r;
  state_t           state_s;
  logic             accept_s;
  logic             dir_s;
  logic             seq_error_s;
  logic             hall_fault_s;
  logic [2:0]       pos_old_s;
  logic [2:0]       pos_new_s;

  // Position of a code in the forward sequence 001,011,010,110,100,101.
  function automatic logic [2:0] hall_pos(input logic [2:0] code);
    logic [2:0] pos;
    case (code)
      3'b001:  pos = 3'd0;
      3'b011:  pos = 3'd1;
      3'b010:  pos = 3'd2;
      3'b110:  pos = 3'd3;
      3'b100:  pos = 3'd4;
      3'b101:  pos = 3'd5;
      default: pos = 3'd0;
    endcase
    return pos;
  endfunction

  // 000 and 111 cannot occur with healthy sensors.
  function automatic logic hall_is_valid(input logic [2:0] code);
    return (code != 3'b000) && (code != 3'b111);
  endfunction

  function automatic logic [2:0] pos_next(input logic [2:0] pos);
    return (pos == 3'd5) ? 3'd0 : pos + 3'd1;
  endfunction

  function automatic logic [2:0] pos_prev(input logic [2:0] pos);
    return (pos == 3'd0) ? 3'd5 : pos - 3'd1;
  endfunction

  // Two-flop synchronizer plus the stability filter (candidate + saturating counter).
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r    <= 3'b000;
      sync2_r    <= 3'b000;
      cand_r     <= 3'b000;
      stab_cnt_r <= {CNT_W{1'b0}};
    end else begin
      sync1_r <= hall_raw;
      sync2_r <= sync1_r;
      if (sync2_r != cand_r) begin
        cand_r     <= sync2_r;
        stab_cnt_r <= {CNT_W{1'b0}};
      end else if (stab_cnt_r != CNT_MAX) begin
        stab_cnt_r <= stab_cnt_r + CNT_ONE;
      end else begin
        stab_cnt_r <= stab_cnt_r;
      end
    end
  end

  // Acceptance decision and next-state / next-output logic of the tracking FSM.
  always_comb begin
    accept_s     = (stab_cnt_r == CNT_MAX) && (cand_r != hall_values);
    pos_old_s    = hall_pos(hall_values);
    pos_new_s    = hall_pos(cand_r);
    state_s      = state_r;
    dir_s        = dir;
    seq_error_s  = 1'b0;
    hall_fault_s = hall_fault;
    if (accept_s) begin
      if (!hall_is_valid(cand_r)) begin
        state_s      = FAULT;
        hall_fault_s = 1'b1;
      end else begin
        hall_fault_s = 1'b0;
        case (state_r)
          TRACK: begin
            if (pos_new_s == pos_next(pos_old_s)) begin
              dir_s = 1'b1;
            end else if (pos_new_s == pos_prev(pos_old_s)) begin
              dir_s = 1'b0;
            end else begin
              seq_error_s = 1'b1;
            end
          end
          IDLE, FAULT: begin
            state_s = TRACK;
          end
          default: begin
            state_s = IDLE;
          end
        endcase
      end
    end else begin
      state_s = state_r;
    end
  end

  // Registered filtered code, edge strobe and FSM outputs.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      hall_values <= 3'b000;
      hall_edge   <= 1'b0;
      state_r     <= IDLE;
      dir         <= 1'b1;
      seq_error   <= 1'b0;
      hall_fault  <= 1'b0;
    end else begin
      hall_values <= accept_s ? cand_r : hall_values;
      hall_edge   <= accept_s;
      state_r     <= state_s;
      dir         <= dir_s;
      seq_error   <= seq_error_s;
      hall_fault  <= hall_fault_s;
    end
  end

`ifdef HALL_PERIOD_EN
  localparam logic [PERIOD_WIDTH-1:0] COUNT_ONE = PERIOD_WIDTH'(1'b1);
  localparam logic [PERIOD_WIDTH-1:0] COUNT_MAX = {PERIOD_WIDTH{1'b1}};

  logic [PERIOD_WIDTH-1:0] count_r;
  logic                    edge_valid_s;
  logic                    track_entry_s;

  // A valid-code edge either measures a period (already tracking) or starts tracking.
  always_comb begin
    edge_valid_s  = accept_s && hall_is_valid(cand_r) && (state_r == TRACK);
    track_entry_s = accept_s && hall_is_valid(cand_r) && (state_r != TRACK);
  end

  // Saturating cycle counter between valid edges and period capture.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r      <= {PERIOD_WIDTH{1'b0}};
      period       <= {PERIOD_WIDTH{1'b0}};
      period_valid <= 1'b0;
    end else begin
      period_valid <= edge_valid_s;
      if (edge_valid_s) begin
        period  <= count_r;
        count_r <= COUNT_ONE;
      end else if (track_entry_s) begin
        count_r <= COUNT_ONE;
      end else if ((state_r != TRACK) || (state_s != TRACK)) begin
        count_r <= {PERIOD_WIDTH{1'b0}};
      end else if (count_r != COUNT_MAX) begin
        count_r <= count_r + COUNT_ONE;
      end else begin
        count_r <= count_r;
      end
    end
  end
`else
  assign period       = {PERIOD_WIDTH{1'b0}};
  assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_hall_input_filter.sv
// Directed self-checking bench for hall_input_filter (FILTER_CYCLES=4, PERIOD_WIDTH=8).
// Period expectations follow HALL_PERIOD_EN: measured values when defined, zero otherwise.
`timescale 1ns/1ps
module tb_hall_input_filter;

  localparam int FC = 4;
  localparam int PW = 8;
`ifdef HALL_PERIOD_EN
  localparam bit PERIOD_EN = 1'b1;
`else
  localparam bit PERIOD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    raw;
  logic [2:0]    hall_values;
  logic          hall_edge;
  logic          dir;
  logic          seq_error;
  logic          hall_fault;
  logic [PW-1:0] period;
  logic          period_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int n_edge   = 0;
  int n_seq    = 0;
  int n_pv     = 0;
  int e0, s0, p0;

  hall_input_filter #(.FILTER_CYCLES(FC), .PERIOD_WIDTH(PW)) dut (
    .sys_clk      (clk),
    .reset_n      (reset_n),
    .hall_raw     (raw),
    .hall_values  (hall_values),
    .hall_edge    (hall_edge),
    .dir          (dir),
    .seq_error    (seq_error),
    .hall_fault   (hall_fault),
    .period       (period),
    .period_valid (period_valid)
  );

  always #5 clk = ~clk;

  // Strobe pulse counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (hall_edge)    n_edge <= n_edge + 1;
    if (seq_error)    n_seq  <= n_seq + 1;
    if (period_valid) n_pv   <= n_pv + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive a raw code and hold it for the given number of clock edges.
  task automatic apply(input logic [2:0] code, input int hold);
    raw = code;
    repeat (hold) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    raw     = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_values", 32'(hall_values), 32'd0);
    check("rst_dir",    32'(dir),         32'd1);
    check("rst_strobe", 32'({hall_edge, seq_error, period_valid, hall_fault}), 32'd0);
    check("rst_period", 32'(period),      32'd0);

    // First acceptance: exactly 2+FC edges after the first sampling edge.
    reset_n = 1'b1;
    raw     = 3'b001;
    repeat (6) @(posedge clk);
    #1;
    check("lat_before", 32'(hall_values), 32'd0);
    @(posedge clk); #1;
    check("lat_values", 32'(hall_values), 32'd1);
    check("lat_edge",   32'(hall_edge),   32'd1);
    @(posedge clk); #1;
    check("edge_width", 32'(hall_edge),   32'd0);
    check("first_seq",  32'(n_seq),       32'd0);
    check("first_pv",   32'(n_pv),        32'd0);
    apply(3'b001, 10);

    // Three-cycle glitch is rejected.
    e0 = n_edge; s0 = n_seq; p0 = n_pv;
    apply(3'b011, 3);
    apply(3'b001, 12);
    check("glitch_values", 32'(hall_values), 32'd1);
    check("glitch_strobes", 32'((n_edge - e0) + (n_seq - s0) + (n_pv - p0)), 32'd0);

    // Forward steps with 100-cycle spacing, then a reverse step.
    apply(3'b011, 100);
    check("fwd1_values", 32'(hall_values), 32'h3);
    check("fwd1_dir",    32'(dir),         32'd1);
    e0 = n_edge; p0 = n_pv;
    apply(3'b010, 100);
    check("fwd2_values", 32'(hall_values), 32'h2);
    check("fwd2_dir",    32'(dir),         32'd1);
    check("fwd2_period", 32'(period),      PERIOD_EN ? 32'd100 : 32'd0);
    check("fwd2_pv",     32'(n_pv - p0),   PERIOD_EN ? 32'd1 : 32'd0);
    check("fwd2_edge",   32'(n_edge - e0), 32'd1);
    apply(3'b011, 100);
    check("rev_values",  32'(hall_values), 32'h3);
    check("rev_dir",     32'(dir),         32'd0);
    check("rev_period",  32'(period),      PERIOD_EN ? 32'd100 : 32'd0);

    // Reverse to 001, then a three-position jump to 110.
    apply(3'b001, 20);
    check("rev2_dir", 32'(dir), 32'd0);
    s0 = n_seq;
    apply(3'b110, 20);
    check("jump_values", 32'(hall_values), 32'h6);
    check("jump_seq",    32'(n_seq - s0),  32'd1);
    check("jump_dir",    32'(dir),         32'd0);

    // Invalid code: fault flag rises together with the code.
    raw = 3'b111;
    repeat (6) @(posedge clk);
    #1;
    check("flt_before", 32'({hall_values, hall_fault}), 32'({3'b110, 1'b0}));
    @(posedge clk); #1;
    check("flt_values", 32'(hall_values), 32'h7);
    check("flt_level",  32'(hall_fault),  32'd1);
    apply(3'b111, 13);
    check("flt_hold",   32'(hall_fault),  32'd1);

    // Recovery from fault: no period on re-entry, then a wrapping forward step.
    p0 = n_pv; s0 = n_seq;
    apply(3'b101, 20);
    check("rec_values", 32'(hall_values), 32'h5);
    check("rec_fault",  32'(hall_fault),  32'd0);
    check("rec_pv",     32'(n_pv - p0),   32'd0);
    check("rec_seq",    32'(n_seq - s0),  32'd0);
    p0 = n_pv;
    apply(3'b001, 20);
    check("wrap_dir",    32'(dir),       32'd1);
    check("wrap_pv",     32'(n_pv - p0), PERIOD_EN ? 32'd1 : 32'd0);
    check("wrap_period", 32'(period),    PERIOD_EN ? 32'd20 : 32'd0);

    // Long hold: period saturates at all ones.
    apply(3'b011, 300);
    apply(3'b010, 20);
    check("sat_dir",    32'(dir),    32'd1);
    check("sat_period", 32'(period), PERIOD_EN ? 32'hFF : 32'd0);

    // Reset in the middle of filtering a new code.
    apply(3'b110, 3);
    reset_n = 1'b0;
    #1;
    check("mrst_values", 32'(hall_values), 32'd0);
    check("mrst_dir",    32'(dir),         32'd1);
    check("mrst_period", 32'(period),      32'd0);
    check("mrst_strobe", 32'({hall_edge, seq_error, period_valid, hall_fault}), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("refilter_before", 32'(hall_values), 32'd0);
    s0 = n_seq;
    @(posedge clk); #1;
    check("refilter_values", 32'(hall_values), 32'h6);
    check("refilter_edge",   32'(hall_edge),   32'd1);
    @(posedge clk); #1;
    check("refilter_seq",    32'(n_seq - s0),  32'd0);
    check("refilter_dir",    32'(dir),         32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hall_input_filter.md
HALL_INPUT_FILTER -- requirements
Module: hall_input_filter

Interface
REQ-001 SHALL have parameter FILTER_CYCLES, default 16: consecutive stable cycles (>=2) needed to accept a new hall code.
REQ-002 SHALL have parameter PERIOD_WIDTH, default 24: width of the commutation period counter.
REQ-003 SHALL have input sys_clk, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have input reset_n, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have input hall_raw, 3 bits: asynchronous hall sensor pins, bit0 = sensor A.
REQ-006 SHALL have output hall_values, 3 bits: filtered hall code, typed hall_states_t, feeding the BLDC peripheral.
REQ-007 SHALL have output hall_edge, 1 bit: one-cycle strobe when hall_values changes.
REQ-008 SHALL have output dir, 1 bit: 1 = forward, 0 = reverse.
REQ-009 SHALL have output seq_error, 1 bit: one-cycle strobe on an accepted non-adjacent transition.
REQ-010 SHALL have output hall_fault, 1 bit: level, high while the accepted code is 000 or 111.
REQ-011 SHALL have output period, PERIOD_WIDTH bits: cycles between the last two valid edges.
REQ-012 SHALL have output period_valid, 1 bit: one-cycle strobe when period updates.

Function
REQ-013 SHALL pass hall_raw through a 2-flop synchronizer; sync output = s2.
REQ-014 SHALL hold candidate and stable counter: if s2 != candidate, candidate <= s2 and counter <= 0; else counter increments, saturating at FILTER_CYCLES-1.
REQ-015 SHALL accept the candidate when counter == FILTER_CYCLES-1 and candidate != hall_values; hall_values updates on the next edge with hall_edge high for that one cycle.
REQ-016 SHALL reject glitches shorter than FILTER_CYCLES cycles without changing any output; end-to-end latency = 2 + FILTER_CYCLES cycles.
REQ-017 SHALL use forward sequence 001->011->010->110->100->101->001 (wraps at 101->001).
REQ-018 SHALL run FSM states IDLE, TRACK, FAULT; reset state IDLE.
REQ-019 IDLE: accepted valid code -> TRACK, dir unchanged, no seq_error, no period update; accepted 000/111 -> FAULT.
REQ-020 TRACK: next-in-sequence sets dir=1; previous-in-sequence sets dir=0; a jump of two or three positions pulses seq_error, leaves dir unchanged, stays TRACK.
REQ-021 TRACK or IDLE: accepted 000/111 -> FAULT and hall_fault high in the same cycle as hall_values.
REQ-022 FAULT: accepted valid code -> IDLE-equivalent handling (hall_fault low, no dir/seq_error/period update) then TRACK.
REQ-023 SHALL count cycles since the last valid accepted edge, saturating at all ones, never wrapping.
REQ-024 On a valid edge in TRACK: period <= count, period_valid pulses, count <= 1; when saturated, period reports all ones.
REQ-025 Entering FAULT or IDLE SHALL clear the count; the first edge after re-entry produces no period_valid.

Reset
REQ-026 reset_n low SHALL asynchronously clear sync flops, candidate, counter, hall_values, period, count to 0, dir to 1, all strobes and hall_fault to 0, FSM to IDLE.
REQ-027 Reset mid-filter SHALL discard the pending candidate; after release, the code must again be stable for FILTER_CYCLES cycles to be accepted.

Configuration
REQ-028 Macro HALL_PERIOD_EN defined: period counter and REQ-023..025 implemented.
REQ-029 Macro HALL_PERIOD_EN undefined: no counter logic; period tied 0, period_valid tied 0; all other behaviour identical.

Verification (FILTER_CYCLES=4, HALL_PERIOD_EN defined unless noted)
REQ-030 Reset, hold raw=001 -> hall_values=001 and hall_edge exactly 6 cycles after first sampled edge; FSM TRACK; no seq_error.
REQ-031 From 001, pulse raw=011 for 3 cycles then back -> hall_values stays 001, no strobes.
REQ-032 Sequence 001,011,010 each held 100 cycles -> dir=1; second edge gives period=100, period_valid once; then 011 -> dir=0.
REQ-033 From 001 jump to 110 -> seq_error one cycle, dir unchanged; then 111 -> hall_fault=1; then 101 -> hall_fault=0, no period_valid.
REQ-034 Hold code 2^PERIOD_WIDTH+10 cycles then valid edge -> period all ones; assert reset_n mid-filter -> outputs 0 immediately.
REQ-035 HALL_PERIOD_EN undefined, repeat REQ-032 -> identical hall_values/dir, period=0, period_valid never high.
